// File: rtl/dac_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_sched_pkg
// Brief    : Shared constants, FSM state type and WRU word builder for the
//            DAC update scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package dac_sched_pkg;

    localparam logic [3:0]  DAC_CMD_WRU = 4'h3;
    localparam logic [3:0]  DAC_CMD_NOP = 4'hF;
    localparam logic [15:0] ZERO_CODE   = 16'h8000;
    localparam int unsigned NUM_CH      = 4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        FIRE       = 3'd2,
        WAIT_START = 3'd3,
        WAIT_DONE  = 3'd4
    } sched_state_t;

    // Write-and-update-register command word for one channel code.
    function automatic logic [31:0] build_wru_word(input logic [15:0] code);
        return {8'h00, DAC_CMD_WRU, 4'h0, code};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_refresh_timer.sv
`default_nettype none
// ============================================================================
// Module   : dac_refresh_timer
// Brief    : Free-running refresh interval counter with a sticky request flag.
// Revision : 1.0 - initial release
// ============================================================================
module dac_refresh_timer #(
    parameter int unsigned REFRESH_CYCLES = 49152
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    input  logic clr,
    output logic refresh_pend
);

    localparam int unsigned   CW     = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(REFRESH_CYCLES - 1);

    logic [CW-1:0] r_cnt_q;
    logic [CW-1:0] w_cnt_d;
    logic          r_pend_q;
    logic          w_pend_d;
    logic          w_wrap;

    always_comb begin
        w_wrap   = en && !restart && (r_cnt_q == C_LAST);
        w_cnt_d  = r_cnt_q + 1'b1;
        if (restart || !en || w_wrap) begin
            w_cnt_d = '0;
        end
        w_pend_d = r_pend_q;
        if (clr) begin
            w_pend_d = 1'b0;
        end
        if (w_wrap) begin
            w_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q  <= '0;
            r_pend_q <= 1'b0;
        end else begin
            r_cnt_q  <= w_cnt_d;
            r_pend_q <= w_pend_d;
        end
    end

    assign refresh_pend = r_pend_q;

endmodule
`default_nettype wire

// File: rtl/dac_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dac_update_scheduler
// Brief    : Double-buffered 4-channel DAC setpoints; arbitrates safe-state,
//            commit and refresh updates into the SPI serializer.
// Revision : 1.0 - initial release
// ============================================================================
module dac_update_scheduler #(
    parameter int unsigned REFRESH_CYCLES = 49152,
    parameter int unsigned BUSY_TIMEOUT   = 1024,
    parameter logic [15:0] ZERO_CODE      = dac_sched_pkg::ZERO_CODE
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        host_wen,
    input  logic [1:0]  host_chan,
    input  logic [15:0] host_code,
    input  logic        host_commit,
    input  logic        wdog_expired,
    input  logic        refresh_en,
    input  logic        err_clr,
    input  logic        dac_busy,
    output logic        dac_wen,
    output logic [1:0]  dac_waddr,
    output logic [31:0] dac_wdata,
    output logic        dac_trig,
    output logic        safe_active,
    output logic        overrun,
    output logic        timeout_err,
    output logic [63:0] code_rd
);

    import dac_sched_pkg::*;

    localparam int unsigned   TW          = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0] C_WAIT_LAST = TW'(BUSY_TIMEOUT - 1);

    logic [3:0][15:0] r_staging_q, w_staging_d;
    logic [3:0][15:0] r_active_q,  w_active_d;
    logic [3:0][15:0] r_snap_q,    w_snap_d;
    sched_state_t     r_state_q,   w_state_d;
    logic [1:0]       r_ch_q,      w_ch_d;
    logic [TW-1:0]    r_wait_q,    w_wait_d;
    logic             r_commit_pend_q, w_commit_pend_d;
    logic             r_safe_pend_q,   w_safe_pend_d;
    logic             r_safe_active_q, w_safe_active_d;
    logic             r_wdog_q;
    logic             r_overrun_q,     w_overrun_d;
    logic             r_timeout_q,     w_timeout_d;
    logic             r_wen_q,         w_wen_d;
    logic [1:0]       r_waddr_q,       w_waddr_d;
    logic [31:0]      r_wdata_q,       w_wdata_d;
    logic             r_trig_q,        w_trig_d;
    logic             w_wdog_rise;
    logic             w_start;
    logic             w_emit;
    logic             w_refresh_pend;
    logic [15:0]      w_eff_code;

    dac_refresh_timer #(
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk          (sysclk),
        .rst          (reset),
        .en           (refresh_en),
        .restart      (w_start),
        .clr          (w_start),
        .refresh_pend (w_refresh_pend)
    );

    always_comb begin
        w_wdog_rise = wdog_expired & ~r_wdog_q;

        w_staging_d = r_staging_q;
        if (host_wen) begin
            w_staging_d[host_chan] = host_code;
        end
        w_active_d = r_active_q;
        if (host_commit) begin
            w_active_d = w_staging_d;
        end

        w_safe_active_d = r_safe_active_q;
        if (w_wdog_rise) begin
            w_safe_active_d = 1'b1;
        end else if (host_commit && !wdog_expired) begin
            w_safe_active_d = 1'b0;
        end

        // Every transaction sends the full state, so the safe > commit > refresh
        // priority collapses to "any request starts one and clears them all".
        // Same-cycle events are already folded into that transaction.
        w_start = (r_state_q == IDLE) &&
                  (r_safe_pend_q || w_wdog_rise || r_commit_pend_q ||
                   host_commit || w_refresh_pend);

        w_safe_pend_d   = w_start ? 1'b0 : (r_safe_pend_q | w_wdog_rise);
        w_commit_pend_d = w_start ? 1'b0 : (r_commit_pend_q | host_commit);
        w_snap_d        = w_start ? w_active_d : r_snap_q;

        w_overrun_d = r_overrun_q;
        if (err_clr) begin
            w_overrun_d = 1'b0;
        end
        if (host_commit && r_commit_pend_q) begin
            w_overrun_d = 1'b1;
        end

        w_timeout_d = r_timeout_q;
        if (err_clr) begin
            w_timeout_d = 1'b0;
        end

        w_state_d = r_state_q;
        w_ch_d    = r_ch_q;
        w_wait_d  = r_wait_q;
        w_trig_d  = 1'b0;
        w_emit    = 1'b0;

        case (r_state_q)
            IDLE: begin
                if (w_start) begin
                    w_state_d = LOAD;
                    w_ch_d    = 2'd0;
                    w_emit    = 1'b1;
                end
            end
            LOAD: begin
                if (r_ch_q == 2'd3) begin
                    w_state_d = FIRE;
                    w_trig_d  = 1'b1;
                end else begin
                    w_ch_d = r_ch_q + 2'd1;
                    w_emit = 1'b1;
                end
            end
            FIRE: begin
                w_state_d = WAIT_START;
                w_wait_d  = '0;
            end
            WAIT_START: begin
                if (dac_busy) begin
                    w_state_d = WAIT_DONE;
                    w_wait_d  = '0;
                end else if (r_wait_q == C_WAIT_LAST) begin
                    w_state_d   = IDLE;
                    w_timeout_d = 1'b1;
                end else begin
                    w_wait_d = r_wait_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!dac_busy) begin
                    w_state_d = IDLE;
                end else if (r_wait_q == C_WAIT_LAST) begin
                    w_state_d   = IDLE;
                    w_timeout_d = 1'b1;
                end else begin
                    w_wait_d = r_wait_q + 1'b1;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // Safe state is sampled per word so a mid-sequence watchdog still lands.
        w_eff_code = w_safe_active_d ? ZERO_CODE : w_snap_d[w_ch_d];
        w_wen_d    = w_emit;
        w_waddr_d  = w_emit ? w_ch_d : 2'd0;
        w_wdata_d  = w_emit ? build_wru_word(w_eff_code) : 32'h0;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_staging_q     <= {NUM_CH{ZERO_CODE}};
            r_active_q      <= {NUM_CH{ZERO_CODE}};
            r_snap_q        <= {NUM_CH{ZERO_CODE}};
            r_state_q       <= IDLE;
            r_ch_q          <= 2'd0;
            r_wait_q        <= '0;
            r_commit_pend_q <= 1'b0;
            r_safe_pend_q   <= 1'b0;
            r_safe_active_q <= 1'b0;
            r_wdog_q        <= 1'b0;
            r_overrun_q     <= 1'b0;
            r_timeout_q     <= 1'b0;
            r_wen_q         <= 1'b0;
            r_waddr_q       <= 2'd0;
            r_wdata_q       <= 32'h0;
            r_trig_q        <= 1'b0;
        end else begin
            r_staging_q     <= w_staging_d;
            r_active_q      <= w_active_d;
            r_snap_q        <= w_snap_d;
            r_state_q       <= w_state_d;
            r_ch_q          <= w_ch_d;
            r_wait_q        <= w_wait_d;
            r_commit_pend_q <= w_commit_pend_d;
            r_safe_pend_q   <= w_safe_pend_d;
            r_safe_active_q <= w_safe_active_d;
            r_wdog_q        <= wdog_expired;
            r_overrun_q     <= w_overrun_d;
            r_timeout_q     <= w_timeout_d;
            r_wen_q         <= w_wen_d;
            r_waddr_q       <= w_waddr_d;
            r_wdata_q       <= w_wdata_d;
            r_trig_q        <= w_trig_d;
        end
    end

    assign dac_wen     = r_wen_q;
    assign dac_waddr   = r_waddr_q;
    assign dac_wdata   = r_wdata_q;
    assign dac_trig    = r_trig_q;
    assign safe_active = r_safe_active_q;
    assign overrun     = r_overrun_q;
    assign timeout_err = r_timeout_q;
    assign code_rd     = r_active_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_update_scheduler
// Brief    : Self-checking bench: table-driven setpoints plus scoreboarded
//            command words and hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_update_scheduler;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic        host_wen = 1'b0;
    logic [1:0]  host_chan = 2'd0;
    logic [15:0] host_code = 16'h0;
    logic        host_commit = 1'b0;
    logic        wdog_expired = 1'b0;
    logic        refresh_en = 1'b0;
    logic        err_clr = 1'b0;
    logic        dac_busy = 1'b0;
    logic        dac_wen;
    logic [1:0]  dac_waddr;
    logic [31:0] dac_wdata;
    logic        dac_trig;
    logic        safe_active;
    logic        overrun;
    logic        timeout_err;
    logic [63:0] code_rd;

    dac_update_scheduler #(
        .REFRESH_CYCLES (100),
        .BUSY_TIMEOUT   (1024),
        .ZERO_CODE      (16'h8000)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .host_wen     (host_wen),
        .host_chan    (host_chan),
        .host_code    (host_code),
        .host_commit  (host_commit),
        .wdog_expired (wdog_expired),
        .refresh_en   (refresh_en),
        .err_clr      (err_clr),
        .dac_busy     (dac_busy),
        .dac_wen      (dac_wen),
        .dac_waddr    (dac_waddr),
        .dac_wdata    (dac_wdata),
        .dac_trig     (dac_trig),
        .safe_active  (safe_active),
        .overrun      (overrun),
        .timeout_err  (timeout_err),
        .code_rd      (code_rd)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [1:0]  chan;
        logic [15:0] code;
        logic [31:0] exp_word;
    } vec_t;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] word;
    } exp_t;

    vec_t tbl [4];
    exp_t exp_q [$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_err = 0;
    int edge_n = 0;
    int trig_cnt = 0;
    int trig_edge = 0;
    int wen_first_edge = 0;
    int wen_run = 0;
    int last_run = 0;
    bit busy_en = 1'b0;
    int busy_len = 200;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int val, input int lo, input int hi);
        n_cmp++;
        if (val < lo || val > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    task automatic push_word(input logic [1:0] a, input logic [15:0] c);
        exp_t e;
        e.addr = a;
        e.word = {8'h00, 4'h3, 4'h0, c};
        exp_q.push_back(e);
    endtask

    task automatic push_all(input logic [15:0] c0, input logic [15:0] c1,
                            input logic [15:0] c2, input logic [15:0] c3);
        push_word(2'd0, c0);
        push_word(2'd1, c1);
        push_word(2'd2, c2);
        push_word(2'd3, c3);
    endtask

    task automatic stage(input logic [1:0] ch, input logic [15:0] code);
        @(negedge sysclk);
        host_wen = 1'b1; host_chan = ch; host_code = code;
        @(negedge sysclk);
        host_wen = 1'b0;
    endtask

    task automatic commit(input bit wen, input logic [1:0] ch, input logic [15:0] code,
                          output int ce);
        @(negedge sysclk);
        host_commit = 1'b1; host_wen = wen; host_chan = ch; host_code = code;
        ce = edge_n + 1;
        @(negedge sysclk);
        host_commit = 1'b0; host_wen = 1'b0;
    endtask

    task automatic pulse_err_clr();
        @(negedge sysclk);
        err_clr = 1'b1;
        @(negedge sysclk);
        err_clr = 1'b0;
    endtask

    task automatic wait_trig(input int prev, input int bound, input string name);
        int k = 0;
        while (trig_cnt == prev && k < bound) begin
            @(negedge sysclk);
            k++;
        end
        chk(name, 64'(trig_cnt - prev), 64'd1);
    endtask

    task automatic wait_busy(input logic v, input int bound, input string name);
        int k = 0;
        while (dac_busy !== v && k < bound) begin
            @(negedge sysclk);
            k++;
        end
        chk(name, dac_busy, v);
    endtask

    task automatic wait_idle(input string name);
        wait_busy(1'b1, 20, {name, "_busy_rise"});
        wait_busy(1'b0, busy_len + 20, {name, "_busy_fall"});
        repeat (3) @(negedge sysclk);
    endtask

    initial forever begin
        @(posedge sysclk);
        edge_n++;
    end

    // Scoreboard monitor: every command write must match the next expected word.
    initial forever begin
        @(posedge sysclk);
        #1;
        if (!reset && dac_wen) begin
            if (wen_run == 0) wen_first_edge = edge_n;
            wen_run++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_wen: got addr %0d data %0h, expected no write",
                         dac_waddr, dac_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wen_addr", 64'(dac_waddr), 64'(mon_e.addr));
                chk("wen_data", 64'(dac_wdata), 64'(mon_e.word));
            end
        end
        if (!reset && dac_trig) begin
            trig_cnt++;
            trig_edge = edge_n;
            last_run  = wen_run;
            wen_run   = 0;
        end
    end

    // Serializer model: busy rises 3 cycles after trig and stays high busy_len cycles.
    initial forever begin
        @(posedge sysclk);
        #1;
        if (dac_trig && busy_en && !reset) begin
            repeat (3) @(negedge sysclk);
            dac_busy = 1'b1;
            repeat (busy_len) @(negedge sysclk);
            dac_busy = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int ce;
        int prev;
        int prev2;
        int tr;
        int en_e;
        int last;
        int k;

        tbl[0] = '{2'd0, 16'h1111, 32'h00301111};
        tbl[1] = '{2'd1, 16'h2222, 32'h00302222};
        tbl[2] = '{2'd2, 16'h3333, 32'h00303333};
        tbl[3] = '{2'd3, 16'h4444, 32'h00304444};

        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
        chk("rst_wen", dac_wen, 1'b0);
        chk("rst_trig", dac_trig, 1'b0);
        chk("rst_waddr", dac_waddr, 2'd0);
        chk("rst_wdata", dac_wdata, 32'h0);
        chk("rst_safe", safe_active, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);
        chk("rst_code_rd", code_rd, {4{16'h8000}});

        // Table-driven staging writes, then one commit.
        busy_en = 1'b1;
        for (int i = 0; i < 4; i++) stage(tbl[i].chan, tbl[i].code);
        for (int i = 0; i < 4; i++) exp_q.push_back('{tbl[i].chan, tbl[i].exp_word});
        prev = trig_cnt;
        commit(1'b0, 2'd0, 16'h0, ce);
        wait_trig(prev, 20, "t1_trig");
        chk("t1_wen_latency", 64'(wen_first_edge), 64'(ce));
        chk("t1_trig_latency", 64'(trig_edge), 64'(ce + 4));
        chk("t1_wen_count", 64'(last_run), 64'd4);
        chk("t1_code_rd", code_rd, {16'h4444, 16'h3333, 16'h2222, 16'h1111});

        // Two commits during busy: one follow-up, the second one flags overrun.
        wait_busy(1'b1, 20, "t2_busy_rise");
        push_all(16'h5555, 16'h6666, 16'h3333, 16'h4444);
        prev = trig_cnt;
        stage(2'd0, 16'h5555);
        commit(1'b0, 2'd0, 16'h0, ce);
        chk("t2_no_overrun", overrun, 1'b0);
        stage(2'd1, 16'h6666);
        commit(1'b0, 2'd0, 16'h0, ce);
        chk("t2_overrun_set", overrun, 1'b1);
        pulse_err_clr();
        chk("t2_overrun_clr", overrun, 1'b0);
        wait_busy(1'b0, 300, "t2_busy_fall");
        wait_trig(prev, 30, "t2_followup");
        chk("t2_code_rd", code_rd, {16'h4444, 16'h3333, 16'h6666, 16'h5555});
        wait_idle("t2");
        repeat (20) @(negedge sysclk);
        chk("t2_single_followup", 64'(trig_cnt), 64'(prev + 1));

        // Watchdog safe state.
        for (int i = 0; i < 4; i++) stage(2'(i), 16'h1234);
        push_all(16'h1234, 16'h1234, 16'h1234, 16'h1234);
        prev = trig_cnt;
        commit(1'b0, 2'd0, 16'h0, ce);
        wait_trig(prev, 20, "t3_setup");
        wait_idle("t3a");
        @(negedge sysclk);
        wdog_expired = 1'b1;
        push_all(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        prev = trig_cnt;
        wait_trig(prev, 20, "t3_wdog_trig");
        chk("t3_safe_set", safe_active, 1'b1);
        chk("t3_code_rd_kept", code_rd, {4{16'h1234}});
        wait_idle("t3b");
        push_all(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        prev = trig_cnt;
        commit(1'b0, 2'd0, 16'h0, ce);
        wait_trig(prev, 20, "t3_commit_wdog_high");
        chk("t3_safe_held", safe_active, 1'b1);
        wait_idle("t3c");
        @(negedge sysclk);
        wdog_expired = 1'b0;
        push_all(16'h1234, 16'h1234, 16'h1234, 16'h1234);
        prev = trig_cnt;
        commit(1'b0, 2'd0, 16'h0, ce);
        wait_trig(prev, 20, "t3_leave_safe");
        chk("t3_safe_clr", safe_active, 1'b0);
        wait_idle("t3d");

        // Periodic refresh with a short busy pulse.
        busy_len = 5;
        @(negedge sysclk);
        refresh_en = 1'b1;
        en_e = edge_n + 1;
        last = 0;
        for (int r = 0; r < 3; r++) begin
            push_all(16'h1234, 16'h1234, 16'h1234, 16'h1234);
            prev = trig_cnt;
            wait_trig(prev, 150, "t4_refresh_trig");
            if (r == 0) chk_range("t4_first_delay", trig_edge - en_e, 100, 106);
            else        chk_range("t4_period", trig_edge - last, 100, 102);
            last = trig_edge;
        end
        @(negedge sysclk);
        refresh_en = 1'b0;
        wait_idle("t4");
        busy_len = 200;

        // Busy never asserted: timeout, then a pending commit is still serviced.
        busy_en = 1'b0;
        push_all(16'h1234, 16'h1234, 16'h1234, 16'h1234);
        prev = trig_cnt;
        commit(1'b0, 2'd0, 16'h0, ce);
        wait_trig(prev, 20, "t5_trig");
        tr = trig_edge;
        repeat (10) @(negedge sysclk);
        push_all(16'h1234, 16'h1234, 16'h1234, 16'h1234);
        prev2 = trig_cnt;
        commit(1'b0, 2'd0, 16'h0, ce);
        k = 0;
        while (!timeout_err && k < 1200) begin
            @(negedge sysclk);
            k++;
        end
        chk_range("t5_timeout_delay", edge_n - tr, 1023, 1027);
        busy_en = 1'b1;
        wait_trig(prev2, 30, "t5_pending_served");
        wait_idle("t5");
        chk("t5_timeout_sticky", timeout_err, 1'b1);
        pulse_err_clr();
        chk("t5_timeout_clr", timeout_err, 1'b0);

        // Reset in the second LOAD cycle; same-cycle staging write is included.
        push_word(2'd0, 16'hBEEF);
        push_word(2'd1, 16'h1234);
        prev = trig_cnt;
        commit(1'b1, 2'd0, 16'hBEEF, ce);
        @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        chk("t6_wen_after_rst", dac_wen, 1'b0);
        chk("t6_trig_after_rst", dac_trig, 1'b0);
        chk("t6_code_rd_rst", code_rd, {4{16'h8000}});
        reset = 1'b0;
        wen_run = 0;
        repeat (20) @(negedge sysclk);
        chk("t6_no_trig", 64'(trig_cnt), 64'(prev));
        chk("t6_no_wen", 64'(wen_run), 64'd0);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
